// File: rtl/ps2_kbd_pkg.sv
// Shared types and byte constants for the PS/2 scan-code set 2 key event path.
package ps2_kbd_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;

  localparam logic [7:0] ST_ACK    = 8'hFA;
  localparam logic [7:0] ST_BAT    = 8'hAA;
  localparam logic [7:0] ST_ECHO   = 8'hEE;
  localparam logic [7:0] ST_RESEND = 8'hFE;
  localparam logic [7:0] ST_ERR0   = 8'h00;
  localparam logic [7:0] ST_ERR1   = 8'hFF;

  // Pause (E1 14 77 E1 F0 14 F0 77) is swallowed: seven bytes follow the first E1.
  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_E0,
    S_PRE_F0,
    S_PRE_E0F0,
    S_SKIP_E1
  } parse_state_e;

  function automatic logic is_status(input logic [7:0] b);
    return (b == ST_ACK) || (b == ST_BAT) || (b == ST_ECHO) ||
           (b == ST_RESEND) || (b == ST_ERR0) || (b == ST_ERR1);
  endfunction

  function automatic logic [31:0] pack_key_word(input key_evt_t e);
    return {22'd0, e};
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Generic first-word-fall-through FIFO; read data is zero whenever the FIFO is empty.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rstin,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = wr_q - rd_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// Scan-code set 2 parser feeding a FWFT key event FIFO.
// Optional typematic repeat filter enabled by defining KEY_REPEAT_FILTER_EN.
module ps2_key_event_queue
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 2500000,
  parameter bit DROP_BREAK  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstin,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_in,
  input  logic                   pop,
  input  logic                   clear_ovf,
  output logic                   key_avail,
  output logic [31:0]            key_word,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  parse_state_e  state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovf_q, ovf_d;
  logic          tmo_hit;
  logic          emit;
  key_evt_t      evt;
  logic          push;
  logic          fifo_full, fifo_empty;
  logic [9:0]    fifo_rdata;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    if (byte_valid) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (byte_in == BYTE_E0)      state_d = S_PRE_E0;
          else if (byte_in == BYTE_F0) state_d = S_PRE_F0;
          else if (byte_in == BYTE_E1) begin
            state_d = S_SKIP_E1;
            skip_d  = E1_SKIP_LEN;
          end
        end
        S_PRE_E0: begin
          if (byte_in == BYTE_F0)      state_d = S_PRE_E0F0;
          else if (byte_in == BYTE_E0) state_d = S_PRE_E0;
          else if (byte_in == BYTE_E1) begin
            state_d = S_SKIP_E1;
            skip_d  = E1_SKIP_LEN;
          end else                     state_d = S_IDLE;
        end
        S_PRE_F0: begin
          if (byte_in == BYTE_F0)      state_d = S_PRE_F0;
          else if (byte_in == BYTE_E0) state_d = S_PRE_E0;
          else                         state_d = S_IDLE;
        end
        S_PRE_E0F0: begin
          if (byte_in == BYTE_E0)      state_d = S_PRE_E0;
          else if (byte_in == BYTE_F0) state_d = S_PRE_E0F0;
          else                         state_d = S_IDLE;
        end
        S_SKIP_E1: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // A stalled prefix is abandoned so a lost byte cannot corrupt the next key.
      if (tmo_hit) begin
        state_d = S_IDLE;
        skip_d  = '0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_comb begin
    emit     = 1'b0;
    evt      = '0;
    evt.code = byte_in;
    if (byte_valid) begin
      case (state_q)
        S_IDLE: emit = !((byte_in == BYTE_E0) || (byte_in == BYTE_F0) ||
                         (byte_in == BYTE_E1) || is_status(byte_in));
        S_PRE_E0: begin
          evt.ext = 1'b1;
          emit    = !((byte_in == BYTE_E0) || (byte_in == BYTE_F0) ||
                      (byte_in == BYTE_E1) || is_status(byte_in));
        end
        S_PRE_F0: begin
          evt.brk = 1'b1;
          emit    = !((byte_in == BYTE_E0) || (byte_in == BYTE_F0));
        end
        S_PRE_E0F0: begin
          evt.ext = 1'b1;
          evt.brk = 1'b1;
          emit    = !((byte_in == BYTE_E0) || (byte_in == BYTE_F0));
        end
        default: emit = 1'b0;
      endcase
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic       held_valid_q, held_valid_d;
  logic       held_ext_q, held_ext_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_match, is_repeat;

  assign held_match = held_valid_q && (held_ext_q == evt.ext) && (held_code_q == evt.code);
  assign is_repeat  = held_match && !evt.brk;

  always_comb begin
    held_valid_d = held_valid_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    if (emit) begin
      if (!evt.brk && !is_repeat) begin
        held_valid_d = 1'b1;
        held_ext_d   = evt.ext;
        held_code_d  = evt.code;
      end else if (evt.brk && held_match) begin
        held_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
    end
  end

  assign push = emit && !is_repeat && !(DROP_BREAK && evt.brk);
`else
  assign push = emit && !(DROP_BREAK && evt.brk);
`endif

  // A full FIFO only loses the event when no pop frees a slot in the same cycle.
  assign ovf_d = (ovf_q && !clear_ovf) || (push && fifo_full && !pop);

  key_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk     (clk),
    .rstin   (rstin),
    .push_i  (push),
    .wdata_i (evt),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign key_avail = !fifo_empty;
  assign key_word  = pack_key_word(key_evt_t'(fifo_rdata));
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Randomised bench for ps2_key_event_queue: two instances (DROP_BREAK 0 and 1) against a queue-based model.
module tb_ps2_key_event_queue;

  localparam int DEPTH  = 8;
  localparam int TMO    = 16;
  localparam int MSIZE  = 8192;

  logic       clk = 1'b0;
  logic       rstin;
  logic       byteValid;
  logic [7:0] byteIn;
  logic       popReq;
  logic       clearOvf;

  logic        keyAvail0, keyAvail1;
  logic [31:0] keyWord0, keyWord1;
  logic [3:0]  count0, count1;
  logic        ovf0, ovf1;

  int checks   = 0;
  int failures = 0;
  logic checkEn = 1'b0;

  // Model: pending prefix flags plus per-instance event queues.
  logic       mExt, mBrk;
  int         mSkip, mIdle;
  logic       mHeldV;
  logic [8:0] mHeldKey;
  logic [9:0] mStore [2][MSIZE];
  int         mHead [2];
  int         mTail [2];
  logic       mOvf [2];

  logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h00, 8'hFF,
                            8'h1C, 8'h1D, 8'h74, 8'h75, 8'h12, 8'h14, 8'h77};

  always #5 clk = ~clk;

  ps2_key_event_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .DROP_BREAK(1'b0)) dut0 (
    .clk(clk), .rstin(rstin), .byte_valid(byteValid), .byte_in(byteIn), .pop(popReq),
    .clear_ovf(clearOvf), .key_avail(keyAvail0), .key_word(keyWord0), .count(count0),
    .overflow(ovf0));

  ps2_key_event_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .DROP_BREAK(1'b1)) dut1 (
    .clk(clk), .rstin(rstin), .byte_valid(byteValid), .byte_in(byteIn), .pop(popReq),
    .clear_ovf(clearOvf), .key_avail(keyAvail1), .key_word(keyWord1), .count(count1),
    .overflow(ovf1));

  function automatic logic isStatus(input logic [7:0] b);
    return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mExt = 0; mBrk = 0; mSkip = 0; mIdle = 0; mHeldV = 0; mHeldKey = '0;
    for (int i = 0; i < 2; i++) begin
      mHead[i] = 0; mTail[i] = 0; mOvf[i] = 0;
    end
  endtask

  task automatic modelStep(input logic bv, input logic [7:0] b, input logic p, input logic c);
    logic       emit;
    logic [9:0] ev;
    emit = 0;
    ev   = '0;
    if (bv) begin
      mIdle = 0;
      if (mSkip > 0) mSkip--;
      else if (b == 8'hE0) begin mExt = 1; mBrk = 0; end
      else if (b == 8'hF0) mBrk = 1;
      else if (b == 8'hE1 && !mBrk) begin mSkip = 7; mExt = 0; end
      else if (isStatus(b) && !mBrk) mExt = 0;
      else begin
        emit = 1; ev = {mExt, mBrk, b}; mExt = 0; mBrk = 0;
      end
    end else if (mExt || mBrk || mSkip > 0) begin
      mIdle++;
      if (mIdle == TMO) begin
        mExt = 0; mBrk = 0; mSkip = 0; mIdle = 0;
      end
    end
`ifdef KEY_REPEAT_FILTER_EN
    if (emit) begin
      if (!ev[8]) begin
        if (mHeldV && mHeldKey == {ev[9], ev[7:0]}) emit = 0;
        else begin mHeldV = 1; mHeldKey = {ev[9], ev[7:0]}; end
      end else if (mHeldV && mHeldKey == {ev[9], ev[7:0]}) begin
        mHeldV = 0;
      end
    end
`endif
    for (int i = 0; i < 2; i++) begin
      logic doPush, newOvf;
      int   occ;
      doPush = emit && !(i == 1 && ev[8]);
      newOvf = 0;
      occ    = mTail[i] - mHead[i];
      if (p && occ > 0) begin mHead[i]++; occ--; end
      if (doPush) begin
        if (occ < DEPTH) begin
          mStore[i][mTail[i] % MSIZE] = ev;
          mTail[i]++;
        end else newOvf = 1;
      end
      mOvf[i] = (mOvf[i] && !c) || newOvf;
    end
  endtask

  task automatic applyStimulus(input logic bv, input logic [7:0] b, input logic p, input logic c);
    byteValid = bv; byteIn = b; popReq = p; clearOvf = c;
    @(posedge clk);
    modelStep(bv, b, p, c);
    #1;
    byteValid = 0; popReq = 0; clearOvf = 0;
  endtask

  task automatic doReset();
    rstin = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rstin = 1;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        int          occ;
        logic [31:0] expWord;
        occ     = mTail[i] - mHead[i];
        expWord = (occ > 0) ? {22'd0, mStore[i][mHead[i] % MSIZE]} : 32'd0;
        checkOutput($sformatf("key_avail%0d", i), (i == 0) ? 32'(keyAvail0) : 32'(keyAvail1), 32'(occ > 0));
        checkOutput($sformatf("key_word%0d", i), (i == 0) ? keyWord0 : keyWord1, expWord);
        checkOutput($sformatf("count%0d", i), (i == 0) ? 32'(count0) : 32'(count1), 32'(occ));
        checkOutput($sformatf("overflow%0d", i), (i == 0) ? 32'(ovf0) : 32'(ovf1), 32'(mOvf[i]));
      end
    end
  end

  initial begin
    byteValid = 0; byteIn = '0; popReq = 0; clearOvf = 0;
    rstin = 0;
    modelReset();
    checkEn = 1;
    doReset();

    checkOutput("reset_avail", 32'(keyAvail0), 32'd0);
    checkOutput("reset_word", keyWord0, 32'd0);
    checkOutput("reset_count", 32'(count0), 32'd0);
    checkOutput("reset_ovf", 32'(ovf0), 32'd0);

    applyStimulus(1, 8'h1C, 0, 0);
    checkOutput("make_avail", 32'(keyAvail0), 32'd1);
    checkOutput("make_word", keyWord0, 32'h0000001C);
    checkOutput("make_count", 32'(count0), 32'd1);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("pop_avail", 32'(keyAvail0), 32'd0);
    checkOutput("pop_word", keyWord0, 32'd0);

    applyStimulus(1, 8'hE0, 0, 0);
    applyStimulus(1, 8'hF0, 0, 0);
    applyStimulus(1, 8'h74, 0, 0);
    checkOutput("ext_break_word", keyWord0, 32'h00000374);
    checkOutput("drop_break_count", 32'(count1), 32'd0);
    applyStimulus(0, 8'h00, 1, 0);

    for (int i = 0; i < 9; i++) applyStimulus(1, 8'h10 + 8'(i), 0, 0);
    checkOutput("full_count", 32'(count0), 32'd8);
    checkOutput("full_ovf", 32'(ovf0), 32'd1);
    checkOutput("full_head", keyWord0, 32'h00000010);
    applyStimulus(1, 8'h20, 1, 0);
    checkOutput("pushpop_count", 32'(count0), 32'd8);
    checkOutput("pushpop_head", keyWord0, 32'h00000011);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("clear_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 1, 0);

    begin
      logic [7:0] pauseSeq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
      for (int i = 0; i < 9; i++) applyStimulus(1, pauseSeq[i], 0, 0);
    end
    checkOutput("pause_count", 32'(count0), 32'd1);
    checkOutput("pause_word", keyWord0, 32'h0000001C);
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'hAA, 0, 0);
    applyStimulus(1, 8'hFA, 0, 0);
    checkOutput("status_count", 32'(count0), 32'd0);

    applyStimulus(1, 8'hF0, 0, 0);
    for (int i = 0; i < TMO; i++) applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(1, 8'h1C, 0, 0);
    checkOutput("timeout_word", keyWord0, 32'h0000001C);
    applyStimulus(0, 8'h00, 1, 0);

    applyStimulus(1, 8'hE0, 0, 0);
    doReset();
    applyStimulus(1, 8'h75, 0, 0);
    checkOutput("reset_prefix_word", keyWord0, 32'h00000075);
    applyStimulus(0, 8'h00, 1, 0);

    begin
      logic [7:0] repSeq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
      for (int i = 0; i < 6; i++) applyStimulus(1, repSeq[i], 0, 0);
    end
`ifdef KEY_REPEAT_FILTER_EN
    checkOutput("repeat_count0", 32'(count0), 32'd3);
    checkOutput("repeat_count1", 32'(count1), 32'd2);
`else
    checkOutput("repeat_count0", 32'(count0), 32'd5);
    checkOutput("repeat_count1", 32'(count1), 32'd4);
`endif
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      logic       bv, p, c;
      logic [7:0] b;
      if ($urandom_range(0, 999) == 0) doReset();
      if ($urandom_range(0, 99) < 2) begin
        repeat ($urandom_range(TMO - 2, TMO + 2)) applyStimulus(0, 8'h00, 0, 0);
      end
      bv = ($urandom_range(0, 99) < 55);
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      p  = ($urandom_range(0, 99) < 30);
      c  = ($urandom_range(0, 99) < 5);
      applyStimulus(bv, b, p, c);
    end

    @(negedge clk);
    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
